dac_serial_multi: RTL and testbench

Parametrised multi-channel serial DAC writer for AD5626-class devices on the UCD board. It replaces the single-channel writer: one `set` strobe from the sample-rate generator latches all channel words and writes each enabled DAC in turn. The DACs share SCLK and SDIN, and each has its own active-low CS. A single common LDAC pulse then updates all outputs simultaneously. It sits between the filter/ADC datapath and the UCD_io pins.

---
 rtl/dac_serial_multi_if.sv | 26 ++
 rtl/dac_serial_multi.sv | 119 +++++++++++
 tb/tb_dac_serial_multi.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dac_serial_multi_if.sv
// dac_serial_multi_if: sample/control handshake and DAC pin bundle for dac_serial_multi
interface dac_serial_multi_if #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 12
);
    logic [CHANNELS*DATA_WIDTH-1:0] dac_data;
    logic [CHANNELS-1:0]            chan_en;
    logic                           set;
    logic                           busy;
    logic                           done;
    logic                           overrun;
    logic [CHANNELS-1:0]            cs_n;
    logic                           sclk;
    logic                           sdin;
    logic                           ldac_n;

    modport master (
        output dac_data, chan_en, set,
        input  busy, done, overrun, cs_n, sclk, sdin, ldac_n
    );

    modport slave (
        input  dac_data, chan_en, set,
        output busy, done, overrun, cs_n, sclk, sdin, ldac_n
    );
endinterface

// File: rtl/dac_serial_multi.sv
// dac_serial_multi: writes each enabled AD5626-class DAC in turn, then one shared LDAC pulse
module dac_serial_multi #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 12,
    parameter int CLK_DIV    = 4
) (
    input logic               clk,
    input logic               rst,
    dac_serial_multi_if.slave bus
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SELECT   = 3'd1;
    localparam logic [2:0] SHIFT_LO = 3'd2;
    localparam logic [2:0] SHIFT_HI = 3'd3;
    localparam logic [2:0] CS_HOLD  = 3'd4;
    localparam logic [2:0] CS_GAP   = 3'd5;
    localparam logic [2:0] LDAC     = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] shadow [CHANNELS];
    logic [DATA_WIDTH-1:0] shift, shl;
    logic [CHANNELS-1:0]   mask;
    logic [CW-1:0]         ch, nxt;
    logic [DW-1:0]         cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  last, timed;

    // lowest remaining channel, so disabled channels are skipped without spending cycles
    always_comb begin
        nxt = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) nxt = mask[i] ? CW'(i) : nxt;
    end

    assign shl   = shift << 1;
    assign last  = cnt == DW'(CLK_DIV - 1);
    assign timed = state inside {SHIFT_LO, SHIFT_HI, CS_HOLD, CS_GAP, LDAC};

    // all pin outputs are registered so chip selects and strobes cannot glitch on state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mask        <= '0;
            ch          <= '0;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            for (int i = 0; i < CHANNELS; i++) shadow[i] <= '0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.overrun <= 1'b0;
            bus.cs_n    <= '1;
            bus.sclk    <= 1'b0;
            bus.sdin    <= 1'b0;
            bus.ldac_n  <= 1'b1;
        end else begin
            cnt      <= timed && !last ? cnt + DW'(1) : '0;
            bus.done <= 1'b0;
            if (bus.set && state != IDLE) bus.overrun <= 1'b1;
            case (state)
                IDLE: if (bus.set) begin
                    for (int i = 0; i < CHANNELS; i++) shadow[i] <= bus.dac_data[i*DATA_WIDTH +: DATA_WIDTH];
                    mask     <= bus.chan_en;
                    bus.busy <= 1'b1;
                    state    <= SELECT;
                end
                SELECT, CS_GAP: if (state == SELECT || last) begin
                    if (|mask) begin
                        state    <= SHIFT_LO;
                        ch       <= nxt;
                        shift    <= shadow[nxt];
                        bus.sdin <= shadow[nxt][DATA_WIDTH-1];
                        bit_cnt  <= '0;
                        bus.cs_n <= ~(CHANNELS'(1) << nxt);
                    end else if (state == SELECT) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        state      <= LDAC;
                        bus.ldac_n <= 1'b0;
                    end
                end
                SHIFT_LO: if (last) begin
                    state    <= SHIFT_HI;
                    bus.sclk <= 1'b1;
                end
                SHIFT_HI: if (last) begin
                    bus.sclk <= 1'b0;
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        state    <= CS_HOLD;
                        bus.sdin <= 1'b0;
                    end else begin
                        state    <= SHIFT_LO;
                        bit_cnt  <= bit_cnt + BW'(1);
                        shift    <= shl;
                        bus.sdin <= shl[DATA_WIDTH-1];
                    end
                end
                CS_HOLD: if (last) begin
                    state    <= CS_GAP;
                    bus.cs_n <= '1;
                    mask[ch] <= 1'b0;
                end
                LDAC: if (last) begin
                    state      <= DONE;
                    bus.ldac_n <= 1'b1;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_serial_multi.sv
// tb_dac_serial_multi: table-driven and randomized checks of the multi-channel DAC writer
module tb_dac_serial_multi;
    localparam int W = 12;
    localparam int D = 4;
    localparam int F = (2 * W + 1) * D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dac_serial_multi_if #(.CHANNELS(2), .DATA_WIDTH(W)) bus ();
    dac_serial_multi_if #(.CHANNELS(1), .DATA_WIDTH(16)) bus2 ();

    dac_serial_multi #(.CHANNELS(2), .DATA_WIDTH(W), .CLK_DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    dac_serial_multi #(.CHANNELS(1), .DATA_WIDTH(16), .CLK_DIV(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // observer: edge index relative to the accepted set, frames captured as the DAC would see them
    bit mon_rst = 1'b1;
    int rel, done_at, ldac_pulses, ldac_start, ldac_end, viol;
    bit done_busy;
    int fr_ch[$], fr_word[$], fr_bits[$], fr_fall[$], fr_rise[$];
    int cur_ch, cur_word, cur_bits, cur_fall;
    logic [1:0] prev_cs = 2'b11;
    logic prev_sclk = 1'b0, prev_ldac = 1'b1;

    initial forever begin
        @(negedge clk);
        if (mon_rst) begin
            rel = -1; done_at = -1; ldac_pulses = 0; ldac_start = -1; ldac_end = -1; viol = 0;
            fr_ch.delete(); fr_word.delete(); fr_bits.delete(); fr_fall.delete(); fr_rise.delete();
        end else rel++;
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && !bus.cs_n[i]) begin cur_ch = i; cur_word = 0; cur_bits = 0; cur_fall = rel; end
            if (!prev_cs[i] && bus.cs_n[i]) begin
                fr_ch.push_back(cur_ch); fr_word.push_back(cur_word); fr_bits.push_back(cur_bits);
                fr_fall.push_back(cur_fall); fr_rise.push_back(rel);
            end
        end
        if (bus.sclk && !prev_sclk && bus.cs_n != 2'b11) begin cur_word = (cur_word << 1) | int'(bus.sdin); cur_bits++; end
        if ($countones(~bus.cs_n) > 1 || (bus.cs_n == 2'b11 && bus.sdin)) viol++;
        if (prev_ldac && !bus.ldac_n) ldac_start = rel;
        if (!prev_ldac && bus.ldac_n) begin ldac_end = rel; ldac_pulses++; end
        if (bus.done && done_at < 0) begin done_at = rel; done_busy = bus.busy; end
        prev_cs = bus.cs_n; prev_sclk = bus.sclk; prev_ldac = bus.ldac_n;
    end

    function automatic int model_done(input logic [1:0] en);
        int n = $countones(en);
        return n == 0 ? 1 : 1 + n * (F + D) + D;
    endfunction

    task automatic run(input string tag, input logic [1:0] en, input logic [23:0] d, input int exp_done,
                       input int set2_at, input int chg_at, input bit exp_ovr);
        int order[$];
        int n;
        mon_rst = 1'b1;
        @(negedge clk); #1;
        mon_rst = 1'b0; bus.set = 1'b1; bus.chan_en = en; bus.dac_data = d;
        for (int c = 0; c < 3000 && done_at < 0; c++) begin
            @(negedge clk); #1;
            bus.set = (rel == set2_at - 1);
            if (rel == chg_at - 1) begin bus.dac_data = 24'($urandom); bus.chan_en = ~en; end
            if (rel == 0) chk({tag, " busy_after_E0"}, bus.busy, 1);
        end
        bus.set = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (en[i]) order.push_back(i);
        n = order.size();
        chk({tag, " done_edge"}, done_at, exp_done);
        chk({tag, " busy_at_done"}, done_busy, 0);
        chk({tag, " frames"}, fr_ch.size(), n);
        for (int k = 0; k < n && k < fr_ch.size(); k++) begin
            chk({tag, " frame_ch"}, fr_ch[k], order[k]);
            chk({tag, " frame_word"}, fr_word[k], d[order[k]*W +: W]);
            chk({tag, " frame_bits"}, fr_bits[k], W);
            chk({tag, " cs_fall_edge"}, fr_fall[k], 1 + k * (F + D));
            chk({tag, " cs_low_len"}, fr_rise[k] - fr_fall[k], F);
        end
        chk({tag, " ldac_pulses"}, ldac_pulses, n > 0 ? 1 : 0);
        if (n > 0) begin
            chk({tag, " ldac_fall_edge"}, ldac_start, 1 + n * (F + D));
            chk({tag, " ldac_len"}, ldac_end - ldac_start, D);
        end
        chk({tag, " cs_onehot_sdin_idle"}, viol, 0);
        chk({tag, " overrun"}, bus.overrun, exp_ovr);
    endtask

    typedef struct {
        logic [1:0]  en;
        logic [11:0] d0;
        logic [11:0] d1;
        int          done_e;
    } vec_t;
    vec_t tv[4];

    initial begin
        logic [1:0]  en;
        logic [23:0] d;
        logic [15:0] w2;
        int r2, done2, bits2, word2, cslow2, ldlow2;
        logic psclk2;
        tv[0] = '{2'b01, 12'hA5C, 12'h000, 109};
        tv[1] = '{2'b11, 12'h000, 12'hFFF, 213};
        tv[2] = '{2'b10, 12'h3C3, 12'h5A7, 109};
        tv[3] = '{2'b00, 12'h111, 12'h222, 1};
        bus.set = 1'b0; bus.chan_en = '0; bus.dac_data = '0;
        bus2.set = 1'b0; bus2.chan_en = '0; bus2.dac_data = '0;
        repeat (2) @(negedge clk);
        chk("reset cs_n", bus.cs_n, 2'b11);
        chk("reset sclk", bus.sclk, 0);
        chk("reset sdin", bus.sdin, 0);
        chk("reset ldac_n", bus.ldac_n, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset overrun", bus.overrun, 0);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (tv[i]) run($sformatf("vec%0d", i), tv[i].en, {tv[i].d1, tv[i].d0}, tv[i].done_e, -9, -9, 1'b0);

        for (int i = 0; i < 6; i++) begin
            en = 2'($urandom_range(0, 3));
            d  = 24'($urandom);
            run($sformatf("rand%0d", i), en, d, model_done(en), -9, -9, 1'b0);
        end

        run("overrun", 2'b01, {12'h123, 12'hA5C}, 109, 50, 20, 1'b1);

        // reset mid-shift: frame aborted, no LDAC, overrun cleared
        mon_rst = 1'b1;
        @(negedge clk); #1;
        mon_rst = 1'b0; bus.set = 1'b1; bus.chan_en = 2'b01; bus.dac_data = {12'h0F0, 12'h9A6};
        for (int c = 0; c < 200 && rel < 39; c++) begin @(negedge clk); #1; bus.set = 1'b0; end
        chk("midrst cs_n_before", bus.cs_n, 2'b10);
        rst = 1'b1;
        #1;
        chk("midrst cs_n", bus.cs_n, 2'b11);
        chk("midrst sclk", bus.sclk, 0);
        chk("midrst sdin", bus.sdin, 0);
        chk("midrst ldac_n", bus.ldac_n, 1);
        chk("midrst busy", bus.busy, 0);
        chk("midrst overrun", bus.overrun, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("midrst ldac_pulses", ldac_pulses, 0);
        chk("midrst no_done", done_at, -1);
        run("after_rst", 2'b11, {12'hC35, 12'h7E1}, 213, -9, -9, 1'b0);

        // fastest setting: CLK_DIV=1, 16-bit word, one channel
        w2 = 16'($urandom);
        bus2.chan_en = 1'b1; bus2.dac_data = w2;
        @(negedge clk); #1;
        bus2.set = 1'b1;
        r2 = -1; done2 = -1; bits2 = 0; word2 = 0; cslow2 = 0; ldlow2 = 0; psclk2 = 1'b0;
        for (int c = 0; c < 200 && done2 < 0; c++) begin
            @(negedge clk);
            r2++;
            if (bus2.sclk && !psclk2 && !bus2.cs_n[0]) begin word2 = (word2 << 1) | int'(bus2.sdin); bits2++; end
            if (!bus2.cs_n[0]) cslow2++;
            if (!bus2.ldac_n) ldlow2++;
            if (bus2.done) done2 = r2;
            psclk2 = bus2.sclk;
            #1 bus2.set = 1'b0;
        end
        chk("fast done_edge", done2, 36);
        chk("fast word", word2, w2);
        chk("fast bits", bits2, 16);
        chk("fast cs_low_len", cslow2, 33);
        chk("fast ldac_len", ldlow2, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
